mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported MEMORY block between the instruction-fetch requester (I, read-only)
//  and the load/store requester (D, read/write). Issues at most one access per cycle.
//  Tracks which requester owns the read data returning one cycle later and routes it back.
//  Blocks D writes into the instruction region.
//  Sits between the CPU core and MEMORY.
// PARAMETERS
//  AW          16     address width, equals `ADDR_WIDTH
//  DW          32     data width, equals `WIDTH
//  IROM_LIMIT  4096   first address above instruction region; D writes below it are faulted
//  STARVE_MAX  4      consecutive I wait cycles before I overrides D; 0 = strict D priority
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous reset, active-low
//  if_req_i     in   1   I access request; held with if_addr_i until if_gnt_o
//  if_addr_i    in   AW  I address
//  if_gnt_o     out  1   I accepted this cycle (combinational)
//  if_rvalid_o  out  1   I read data valid (1 cycle after grant)
//  if_rdata_o   out  DW  I read data, held until next I response
//  d_req_i      in   1   D access request; held with addr/we/wdata until d_gnt_o
//  d_we_i       in   1   1 = write, 0 = read
//  d_addr_i     in   AW  D address
//  d_wdata_i    in   DW  D write data
//  d_gnt_o      out  1   D accepted this cycle (combinational)
//  d_rvalid_o   out  1   D response (read data or write ack), 1 cycle after grant
//  d_rdata_o    out  DW  D read data, held until next D read response
//  d_err_o      out  1   pulses with d_rvalid_o when granted write had addr < IROM_LIMIT
//  mem_read_o   out  1   to MEMORY memread_i
//  mem_write_o  out  1   to MEMORY memwrite_i
//  mem_addr_o   out  AW  to MEMORY memaddr_i
//  mem_wdata_o  out  DW  to MEMORY memwdata_i
//  mem_rdata_i  in   DW  from MEMORY memrdata_o, valid the cycle after the read is issued
// BEHAVIOUR
//  Reset (rst==0 at clk edge):
//   - owner<=NONE, wait_cnt<=0, all rvalid/err<=0, rdata regs<=0.
//   - While rst==0, both gnt and mem_read_o/mem_write_o are forced 0.
//   - A response pending at reset is dropped; no rvalid follows reset.
//  Arbitration (combinational, one grant max per cycle):
//   - Only D requesting -> D; only I requesting -> I.
//   - Both requesting -> D, unless STARVE_MAX!=0 && wait_cnt>=STARVE_MAX, then I.
//  wait_cnt:
//   - +1 each cycle if_req_i && !if_gnt_o; saturates at STARVE_MAX.
//   - Cleared on if_gnt_o or !if_req_i.
//  Memory drive in grant cycle:
//   - mem_addr_o/mem_wdata_o come from the granted requester.
//   - mem_read_o = I grant | D read grant.
//   - mem_write_o = D write grant && d_addr_i>=IROM_LIMIT.
//   - No grant -> mem_read_o=mem_write_o=0; addr/wdata hold the last granted values.
//  Owner state, 2-bit reg: NONE / I / D_RD / D_WR; next = grant outcome of the current cycle.
//   - I    -> if_rvalid_o=1, if_rdata_o<=mem_rdata_i
//   - D_RD -> d_rvalid_o=1, d_rdata_o<=mem_rdata_i
//   - D_WR -> d_rvalid_o=1, d_rdata_o unchanged, d_err_o=fault flag captured at grant
//   - NONE -> no rvalid
//  rvalid/err are registered single-cycle pulses; back-to-back grants give back-to-back responses.
//  Throughput: 1 access/cycle; read latency 1 cycle from grant. Responses cannot be stalled.
//  Faulted write: granted and acked, never reaches MEMORY.
//  Addresses are passed unmodified; device decode stays in MEMORY.
// STRUCTURE
//  - Shared defines header: owner encodings (OWN_NONE/OWN_I/OWN_D_RD/OWN_D_WR), `IROM_BASE_LIMIT.
//  - One sub-module mem_arb_starve_cnt: wait_cnt counter plus starve flag output.
//  - Top: grant logic, memory mux, owner register, response/hold registers.
// TESTING
//  1 I-only reads 0x0000,0x0004,0x0008 on consecutive cycles -> 3 gnts, 3 if_rvalid pulses cycles+1, data in order
//  2 I and D read 0x1000 same cycle -> D gnt, I waits; next cycle I gnt; d_rvalid then if_rvalid on consecutive cycles
//  3 D requests every cycle, I held, STARVE_MAX=4 -> I granted on 5th cycle, D stalls 1 cycle; with STARVE_MAX=0 I never granted
//  4 D write 0x0010 data 0xDEADBEEF -> mem_write_o stays 0, d_rvalid=1 and d_err=1 next cycle; read 0x0010 returns original
//  5 D write 0xFFF0 data 0x1234 -> mem_write_o=1, d_err=0; D write 0x1004 then D read 0x1004 -> d_rdata_o=written value
//  6 rst low in cycle after I grant -> no if_rvalid, gnts 0 during reset, wait_cnt=0 after release

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: response owner encodings
// and the default boundary of the write-protected instruction region.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_e;

  localparam int IROM_BASE_LIMIT = 4096;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Counts consecutive cycles the instruction requester has waited and flags
// when it has waited long enough to override the load/store requester.
module mem_arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_starve
);

  localparam int            CW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (!i_if_req || i_if_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt < LIMIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // With STARVE_MAX of zero the flag never rises: strict load/store priority.
  assign o_starve = (STARVE_MAX != 0) && (r_wait_cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (read-only) and
// load/store, one access per cycle, routing each 1-cycle-late response back.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int IROM_LIMIT = IROM_BASE_LIMIT,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_err_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  owner_e        r_owner;
  owner_e        w_owner_next;
  logic          r_wr_fault;
  logic [AW-1:0] r_addr_hold;
  logic [DW-1:0] r_wdata_hold;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;

  logic w_starve;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_d_fault;
  logic w_if_resp;
  logic w_d_rd_resp;
  logic w_d_wr_resp;

  mem_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (if_req_i),
    .i_if_gnt (w_if_gnt),
    .o_starve (w_starve)
  );

  assign w_d_fault = (32'(d_addr_i) < 32'(IROM_LIMIT));

  // Grant and next owner; nothing is granted while reset is held.
  always_comb begin
    w_if_gnt     = 1'b0;
    w_d_gnt      = 1'b0;
    w_owner_next = OWN_NONE;
    if (rst) begin
      if (if_req_i && (!d_req_i || w_starve)) begin
        w_if_gnt     = 1'b1;
        w_owner_next = OWN_I;
      end else if (d_req_i) begin
        w_d_gnt      = 1'b1;
        w_owner_next = d_we_i ? OWN_D_WR : OWN_D_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_next;
    end
  end

  assign if_gnt_o    = w_if_gnt;
  assign d_gnt_o     = w_d_gnt;
  assign mem_read_o  = w_if_gnt | (w_d_gnt & ~d_we_i);
  // A faulted write is still granted and acked, it just never reaches memory.
  assign mem_write_o = w_d_gnt & d_we_i & ~w_d_fault;
  assign mem_addr_o  = w_if_gnt ? if_addr_i : (w_d_gnt ? d_addr_i : r_addr_hold);
  assign mem_wdata_o = w_d_gnt ? d_wdata_i : r_wdata_hold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_fault   <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_wr_fault <= w_d_gnt & d_we_i & w_d_fault;
      if (w_if_gnt || w_d_gnt) begin
        r_addr_hold <= mem_addr_o;
      end
      if (w_d_gnt) begin
        r_wdata_hold <= d_wdata_i;
      end
    end
  end

  // Responses are masked while reset is low so a pending one is dropped.
  assign w_if_resp   = rst && (r_owner == OWN_I);
  assign w_d_rd_resp = rst && (r_owner == OWN_D_RD);
  assign w_d_wr_resp = rst && (r_owner == OWN_D_WR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_if_resp) begin
        r_if_rdata <= mem_rdata_i;
      end
      if (w_d_rd_resp) begin
        r_d_rdata <= mem_rdata_i;
      end
    end
  end

  assign if_rvalid_o = w_if_resp;
  assign if_rdata_o  = w_if_resp ? mem_rdata_i : r_if_rdata;
  assign d_rvalid_o  = w_d_rd_resp | w_d_wr_resp;
  assign d_rdata_o   = w_d_rd_resp ? mem_rdata_i : r_d_rdata;
  assign d_err_o     = w_d_wr_resp & r_wr_fault;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model
// predicts grants and responses, a separate monitor checks each response.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int IROM   = 4096;
  localparam int STARVE = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dreq_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
    logic          wr;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [DW-1:0] mem_rdata_i = '0;

  logic          if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, d_err_o;
  logic          mem_read_o, mem_write_o;
  logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;

  logic          s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_d_err;
  logic          s_mem_read, s_mem_write;
  logic [DW-1:0] s_if_rdata, s_d_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .IROM_LIMIT(IROM), .STARVE_MAX(STARVE)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Strict-priority variant sharing the same inputs; only its grants are checked.
  mem_port_arbiter #(.AW(AW), .DW(DW), .IROM_LIMIT(IROM), .STARVE_MAX(0)) u_strict (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(s_if_gnt),
    .if_rvalid_o(s_if_rvalid), .if_rdata_o(s_if_rdata),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(s_d_gnt), .d_rvalid_o(s_d_rvalid), .d_rdata_o(s_d_rdata), .d_err_o(s_d_err),
    .mem_read_o(s_mem_read), .mem_write_o(s_mem_write), .mem_addr_o(s_mem_addr),
    .mem_wdata_o(s_mem_wdata), .mem_rdata_i(mem_rdata_i)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  resp_t         exp_i_q [$];
  resp_t         exp_d_q [$];
  logic [AW-1:0] i_todo  [$];
  dreq_t         d_todo  [$];

  logic          i_pend = 1'b0;
  logic          d_pend = 1'b0;
  logic [AW-1:0] i_addr = '0;
  dreq_t         d_cur;
  int            i_waited = 0;
  logic [AW-1:0] last_addr = '0;
  logic          dev_rd = 1'b0;
  logic          dev_wr = 1'b0;
  logic [AW-1:0] dev_addr = '0;
  logic [DW-1:0] dev_wdata = '0;
  logic [DW-1:0] last_i = '0;
  logic [DW-1:0] last_d = '0;
  resp_t         mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {~a, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  // Memory device: op captured mid-cycle, applied at the edge, data 1 cycle later.
  always @(posedge clk) begin
    if (dev_wr) dev_mem[dev_addr] = dev_wdata;
    if (dev_rd) mem_rdata_i <= dev_read(dev_addr);
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic step(input logic rst_v);
    resp_t r;
    logic  eg_i, eg_d;
    @(negedge clk);
    #1;
    if (!i_pend && i_todo.size() > 0) begin i_addr = i_todo.pop_front(); i_pend = 1'b1; end
    if (!d_pend && d_todo.size() > 0) begin d_cur = d_todo.pop_front(); d_pend = 1'b1; end
    rst       = rst_v;
    if_req_i  = i_pend;
    if_addr_i = i_pend ? i_addr : AW'($urandom);
    d_req_i   = d_pend;
    d_we_i    = d_pend ? d_cur.we : 1'($urandom);
    d_addr_i  = d_pend ? d_cur.addr : AW'($urandom);
    d_wdata_i = d_pend ? d_cur.wdata : $urandom;
    #1;
    eg_i = rst_v && i_pend && (!d_pend || (STARVE > 0 && i_waited >= STARVE));
    eg_d = rst_v && d_pend && !eg_i;
    chk("if_gnt", 32'(if_gnt_o), 32'(eg_i));
    chk("d_gnt", 32'(d_gnt_o), 32'(eg_d));
    chk("mem_read", 32'(mem_read_o), 32'(eg_i || (eg_d && !d_cur.we)));
    chk("mem_write", 32'(mem_write_o), 32'(eg_d && d_cur.we && (32'(d_cur.addr) >= IROM)));
    if (rst_v) begin
      chk("mem_addr", 32'(mem_addr_o), 32'(eg_i ? i_addr : (eg_d ? d_cur.addr : last_addr)));
      chk("strict_d_gnt", 32'(s_d_gnt), 32'(d_pend));
      chk("strict_if_gnt", 32'(s_if_gnt), 32'(i_pend && !d_pend));
    end
    if (eg_d && d_cur.we) chk("mem_wdata", mem_wdata_o, d_cur.wdata);
    dev_rd    = mem_read_o;
    dev_wr    = mem_write_o;
    dev_addr  = mem_addr_o;
    dev_wdata = mem_wdata_o;
    if (!rst_v || !i_pend || eg_i) i_waited = 0;
    else i_waited++;
    if (eg_i) begin
      r.due = cyc + 1; r.data = ref_read(i_addr); r.err = 1'b0; r.wr = 1'b0;
      exp_i_q.push_back(r);
      i_pend = 1'b0; last_addr = i_addr;
      $display("cyc=%0d grant I read addr=%h exp=%h", cyc, i_addr, r.data);
    end
    if (eg_d) begin
      r.due = cyc + 1; r.wr = d_cur.we; r.err = 1'b0; r.data = '0;
      if (d_cur.we) begin
        r.err = (32'(d_cur.addr) < IROM);
        if (!r.err) ref_mem[d_cur.addr] = d_cur.wdata;
      end else begin
        r.data = ref_read(d_cur.addr);
      end
      exp_d_q.push_back(r);
      d_pend = 1'b0; last_addr = d_cur.addr;
      $display("cyc=%0d grant D we=%0d addr=%h wdata=%h err=%0d", cyc, d_cur.we, d_cur.addr,
               d_cur.wdata, r.err);
    end
    if (!rst_v) last_addr = '0;
  endtask

  // Response monitor, sampled mid-cycle after the edge.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      chk("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid_o), 32'd0);
      chk("rst_d_err", 32'(d_err_o), 32'd0);
      exp_i_q.delete();
      exp_d_q.delete();
      last_i = '0;
      last_d = '0;
    end else begin
      if (exp_i_q.size() > 0 && exp_i_q[0].due == cyc) begin
        mon_e = exp_i_q.pop_front();
        chk("if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("if_rdata", if_rdata_o, mon_e.data);
        last_i = mon_e.data;
      end else begin
        chk("if_rvalid_idle", 32'(if_rvalid_o), 32'd0);
        chk("if_rdata_hold", if_rdata_o, last_i);
      end
      if (exp_d_q.size() > 0 && exp_d_q[0].due == cyc) begin
        mon_e = exp_d_q.pop_front();
        chk("d_rvalid", 32'(d_rvalid_o), 32'd1);
        chk("d_err", 32'(d_err_o), 32'(mon_e.err));
        if (!mon_e.wr) last_d = mon_e.data;
        chk("d_rdata", d_rdata_o, last_d);
      end else begin
        chk("d_rvalid_idle", 32'(d_rvalid_o), 32'd0);
        chk("d_err_idle", 32'(d_err_o), 32'd0);
        chk("d_rdata_hold", d_rdata_o, last_d);
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] base;
    base = ($urandom_range(0, 1) == 1) ? 16'h0FE0 : 16'hFFC0;
    return base + AW'(4 * $urandom_range(0, 15));
  endfunction

  function automatic dreq_t mk_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    dreq_t d;
    d.we = we; d.addr = a; d.wdata = wd;
    return d;
  endfunction

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1);
  endtask

  initial begin
    dreq_t dr;
    for (int k = 0; k < 3; k++) step(1'b0);
    // I-only consecutive reads
    i_todo.push_back(16'h0000); i_todo.push_back(16'h0004); i_todo.push_back(16'h0008);
    run_idle(5);
    // same-cycle conflict, D first
    i_todo.push_back(16'h1000); d_todo.push_back(mk_d(1'b0, 16'h1000, '0));
    run_idle(4);
    // D every cycle, I held: I wins after STARVE waits
    i_todo.push_back(16'h0100);
    for (int k = 0; k < 7; k++) d_todo.push_back(mk_d(1'b0, AW'(16'h2000 + 4 * k), '0));
    run_idle(10);
    // faulted write into instruction region, then read back original
    d_todo.push_back(mk_d(1'b1, 16'h0010, 32'hDEADBEEF));
    d_todo.push_back(mk_d(1'b0, 16'h0010, '0));
    run_idle(4);
    // legal writes and read-back
    d_todo.push_back(mk_d(1'b1, 16'hFFF0, 32'h0000_1234));
    d_todo.push_back(mk_d(1'b1, 16'h1004, 32'hCAFE_F00D));
    d_todo.push_back(mk_d(1'b0, 16'h1004, '0));
    run_idle(5);
    // reset right after an I grant drops its response
    i_todo.push_back(16'h0020);
    step(1'b1);
    i_todo.push_back(16'h0024); d_todo.push_back(mk_d(1'b0, 16'h1010, '0));
    for (int k = 0; k < 3; k++) step(1'b0);
    run_idle(4);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      if (i_todo.size() == 0 && $urandom_range(0, 99) < 45) i_todo.push_back(rand_addr());
      if (d_todo.size() == 0 && $urandom_range(0, 99) < 55) begin
        dr = mk_d(1'($urandom_range(0, 1)), rand_addr(), $urandom);
        d_todo.push_back(dr);
      end
      step(1'b1);
    end
    for (int n = 0; n < 100 && (i_pend || d_pend || i_todo.size() > 0 || d_todo.size() > 0); n++)
      step(1'b1);
    chk("drain_pending", 32'(i_pend | d_pend), 32'd0);
    run_idle(3);
    chk("resp_q_empty", 32'(exp_i_q.size() + exp_d_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
